// File: rtl/ps2_kbd_rx.sv
// ps2_kbd_rx: PS/2 keyboard receiver front-end.
// The keyboard lines are synchronised and 11-bit frames are deserialised with
// start/parity/stop checking. E0/F0 prefixes are folded into tagged key events,
// which are buffered in a DEPTH-entry FIFO read through a valid/ready port.
// Optional build macro PS2_ASCII_EN adds an 'ascii' output that translates
// the head entry (letters a-z and Enter) combinationally.
module ps2_kbd_rx #(
    parameter int DEPTH       = 8,
    parameter int SYNC_STAGES = 3,
    parameter int TIMEOUT     = 50000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ps2_clk,
    input  logic                     ps2_data,
    input  logic                     clear,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [7:0]               out_code,
    output logic                     out_break,
    output logic                     out_ext,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow,
    output logic [7:0]               err_cnt
`ifdef PS2_ASCII_EN
    ,
    output logic [7:0]               ascii
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } state_t;

    // Synchroniser chains; the last stage is the usable line value
    logic [SYNC_STAGES-1:0] clk_sync_p0;
    logic [SYNC_STAGES-1:0] dat_sync_p0;
    logic                   clk_prev_p0;
    logic                   ps2_fall;
    logic                   ps2_bit;

    // Deserialiser state
    logic [3:0]             bit_cnt;
    logic [TW-1:0]          to_cnt;
    logic [9:0]             frame_bits;
    logic                   last_bit;
    logic                   frame_ok;
    logic                   frame_err;
    logic                   timeout_hit;

    // Byte strobe stage
    logic                   byte_vld_p1;
    logic [7:0]             byte_p1;

    // Prefix decoder
    state_t                 state;
    state_t                 state_nxt;
    logic                   push_req;
    logic [9:0]             push_entry;

    // Push stage
    logic                   push_vld_p2;
    logic [9:0]             push_data_p2;

    // FIFO
    logic [9:0]             mem [DEPTH];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic                   fifo_full;
    logic                   pop;
    logic                   push_ok;
    logic [9:0]             head;

    // Translate a make code into lowercase ASCII; unmapped codes give 0
    function automatic logic [7:0] scan_to_ascii(input logic [7:0] code);
        logic [7:0] a;
        a = 8'h00;
        case (code)
            8'h1C: a = 8'h61; // a
            8'h32: a = 8'h62; // b
            8'h21: a = 8'h63; // c
            8'h23: a = 8'h64; // d
            8'h24: a = 8'h65; // e
            8'h2B: a = 8'h66; // f
            8'h34: a = 8'h67; // g
            8'h33: a = 8'h68; // h
            8'h43: a = 8'h69; // i
            8'h3B: a = 8'h6A; // j
            8'h42: a = 8'h6B; // k
            8'h4B: a = 8'h6C; // l
            8'h3A: a = 8'h6D; // m
            8'h31: a = 8'h6E; // n
            8'h44: a = 8'h6F; // o
            8'h4D: a = 8'h70; // p
            8'h15: a = 8'h71; // q
            8'h2D: a = 8'h72; // r
            8'h1B: a = 8'h73; // s
            8'h2C: a = 8'h74; // t
            8'h3C: a = 8'h75; // u
            8'h2A: a = 8'h76; // v
            8'h1D: a = 8'h77; // w
            8'h22: a = 8'h78; // x
            8'h35: a = 8'h79; // y
            8'h1A: a = 8'h7A; // z
            8'h5A: a = 8'h0D; // Enter
            default: a = 8'h00;
        endcase
        return a;
    endfunction

    // Stage p0: shift raw lines through the synchronisers, remember last clk level
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_sync_p0 <= '1;
            dat_sync_p0 <= '1;
            clk_prev_p0 <= 1'b1;
        end else begin
            clk_sync_p0 <= {clk_sync_p0[SYNC_STAGES-2:0], ps2_clk};
            dat_sync_p0 <= {dat_sync_p0[SYNC_STAGES-2:0], ps2_data};
            clk_prev_p0 <= clk_sync_p0[SYNC_STAGES-1];
        end
    end

    assign ps2_fall    = clk_prev_p0 & ~clk_sync_p0[SYNC_STAGES-1];
    assign ps2_bit     = dat_sync_p0[SYNC_STAGES-1];
    assign last_bit    = ps2_fall && (bit_cnt == 4'd10);
    // bit10 is checked live as it is sampled; frame_bits holds bits 0..9
    assign frame_ok    = ~frame_bits[0] & ps2_bit & (^frame_bits[9:1]);
    assign frame_err   = last_bit && !frame_ok;
    assign timeout_hit = !ps2_fall && (bit_cnt != 4'd0) && (to_cnt == TW'(TIMEOUT));

    // Bit counter and frame watchdog
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt <= 4'd0;
            to_cnt  <= '0;
        end else if (ps2_fall) begin
            to_cnt  <= '0;
            bit_cnt <= (bit_cnt == 4'd10) ? 4'd0 : bit_cnt + 4'd1;
        end else if (bit_cnt == 4'd0) begin
            to_cnt  <= '0;
        end else if (timeout_hit) begin
            to_cnt  <= '0;
            bit_cnt <= 4'd0;
        end else begin
            to_cnt  <= to_cnt + 1'b1;
        end
    end

    // Capture sampled data bits 0..9 of the frame in progress
    always_ff @(posedge clk) begin
        if (ps2_fall && (bit_cnt != 4'd10))
            frame_bits[bit_cnt] <= ps2_bit;
    end

    // Stage p1: byte strobe for a frame that passed all checks
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            byte_vld_p1 <= 1'b0;
        else
            byte_vld_p1 <= last_bit && frame_ok;
    end

    // Stage p1: received byte payload
    always_ff @(posedge clk) begin
        if (last_bit)
            byte_p1 <= frame_bits[8:1];
    end

    // Saturating frame error counter; clear has priority
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            err_cnt <= 8'd0;
        else if (clear)
            err_cnt <= 8'd0;
        else if ((frame_err || timeout_hit) && (err_cnt != 8'hFF))
            err_cnt <= err_cnt + 8'd1;
    end

    // Prefix decoder state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // Prefix decoder next-state logic
    always_comb begin
        state_nxt = state;
        if (byte_vld_p1) begin
            if (byte_p1 == 8'hE0) begin
                if (state == ST_IDLE)
                    state_nxt = ST_EXT;
            end else if (byte_p1 == 8'hF0) begin
                if (state == ST_IDLE)
                    state_nxt = ST_BRK;
                else if (state == ST_EXT)
                    state_nxt = ST_EXT_BRK;
            end else begin
                state_nxt = ST_IDLE;
            end
        end
    end

    // Prefix decoder outputs: event push request and tagged entry
    always_comb begin
        push_req   = byte_vld_p1 && (byte_p1 != 8'hE0) && (byte_p1 != 8'hF0);
        push_entry = {(state == ST_BRK) || (state == ST_EXT_BRK),
                      (state == ST_EXT) || (state == ST_EXT_BRK),
                      byte_p1};
    end

    // Stage p2: registered push request
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            push_vld_p2 <= 1'b0;
        else
            push_vld_p2 <= push_req;
    end

    // Stage p2: registered event entry
    always_ff @(posedge clk) begin
        if (push_req)
            push_data_p2 <= push_entry;
    end

    assign fifo_full = (fifo_count == CW'(DEPTH));
    assign pop       = out_valid && out_ready;
    assign push_ok   = push_vld_p2 && (!fifo_full || pop);

    // FIFO storage write
    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= push_data_p2;
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Sticky overflow flag; clear has priority
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            overflow <= 1'b0;
        else if (clear)
            overflow <= 1'b0;
        else if (push_vld_p2 && fifo_full && !pop)
            overflow <= 1'b1;
    end

    // Head entry presented combinationally, zero when empty
    always_comb begin
        head      = mem[rd_ptr];
        out_valid = (fifo_count != '0);
        out_code  = out_valid ? head[7:0] : 8'h00;
        out_ext   = out_valid & head[8];
        out_break = out_valid & head[9];
    end

`ifdef PS2_ASCII_EN
    // ASCII view of the head entry; make codes of plain keys only
    always_comb begin
        ascii = 8'h00;
        if (out_valid && !out_break && !out_ext)
            ascii = scan_to_ascii(out_code);
    end
`endif

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// tb_ps2_kbd_rx: directed bench for ps2_kbd_rx (DEPTH=4, short TIMEOUT).
// Build with +define+PS2_ASCII_EN to also exercise the ascii output.
module tb_ps2_kbd_rx;

    localparam int DEPTH       = 4;
    localparam int SYNC_STAGES = 3;
    localparam int TIMEOUT     = 64;

    logic                   clk;
    logic                   reset;
    logic                   ps2_clk;
    logic                   ps2_data;
    logic                   clear;
    logic                   out_ready;
    logic                   out_valid;
    logic [7:0]             out_code;
    logic                   out_break;
    logic                   out_ext;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                   overflow;
    logic [7:0]             err_cnt;
`ifdef PS2_ASCII_EN
    logic [7:0]             ascii;
`endif

    int n_cmp;
    int n_err;

    ps2_kbd_rx #(
        .DEPTH      (DEPTH),
        .SYNC_STAGES(SYNC_STAGES),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .clear     (clear),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_code  (out_code),
        .out_break (out_break),
        .out_ext   (out_ext),
        .fifo_count(fifo_count),
        .overflow  (overflow),
        .err_cnt   (err_cnt)
`ifdef PS2_ASCII_EN
        ,
        .ascii     (ascii)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One PS/2 bit cell: data set while clk high, clk low for 8 cycles, high again
    task automatic ps2_slot(input logic b, input logic lat);
        ps2_data = b;
        repeat (4) @(negedge clk);
        ps2_clk = 1'b0;
        if (lat) begin
            repeat (SYNC_STAGES + 2) @(posedge clk);
            #1 chk("lat_pre", out_valid, 0);
            @(posedge clk);
            #1 chk("lat_post", out_valid, 1);
            repeat (3) @(negedge clk);
        end else begin
            repeat (8) @(negedge clk);
        end
        ps2_clk = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    // Send the first nbits of a frame carrying d; bad flips the parity bit
    task automatic send_frame(input logic [7:0] d, input logic bad, input int nbits, input logic lat);
        logic [10:0] f;
        f = {1'b1, (~^d) ^ bad, d, 1'b0};
        for (int i = 0; i < nbits; i++)
            ps2_slot(f[i], lat && (i == 10));
        ps2_data = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic pop_one();
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    initial begin
        logic [7:0] exp_q [4];
        exp_q = '{8'h1C, 8'h32, 8'h21, 8'h23};
        n_cmp     = 0;
        n_err     = 0;
        reset     = 1'b1;
        ps2_clk   = 1'b1;
        ps2_data  = 1'b1;
        clear     = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_err", err_cnt, 0);
        chk("rst_code", out_code, 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // Single make code with latency measurement at the stop bit
        send_frame(8'h1C, 1'b0, 11, 1'b1);
        chk("mk_code", out_code, 8'h1C);
        chk("mk_brk", out_break, 0);
        chk("mk_ext", out_ext, 0);
        chk("mk_count", fifo_count, 1);
`ifdef PS2_ASCII_EN
        chk("mk_ascii", ascii, 8'h61);
`endif
        pop_one();
        chk("mk_popped", fifo_count, 0);

        // Break and extended-break sequences
        send_frame(8'hF0, 1'b0, 11, 1'b0);
        send_frame(8'h1C, 1'b0, 11, 1'b0);
        send_frame(8'hE0, 1'b0, 11, 1'b0);
        send_frame(8'hF0, 1'b0, 11, 1'b0);
        send_frame(8'h75, 1'b0, 11, 1'b0);
        chk("pfx_count", fifo_count, 2);
        chk("pfx0_code", out_code, 8'h1C);
        chk("pfx0_brk", out_break, 1);
        chk("pfx0_ext", out_ext, 0);
`ifdef PS2_ASCII_EN
        chk("pfx0_ascii", ascii, 8'h00);
`endif
        pop_one();
        chk("pfx1_code", out_code, 8'h75);
        chk("pfx1_brk", out_break, 1);
        chk("pfx1_ext", out_ext, 1);
        pop_one();
        chk("pfx_empty", out_valid, 0);

        // Parity error then clear
        send_frame(8'h1C, 1'b1, 11, 1'b0);
        chk("par_count", fifo_count, 0);
        chk("par_err", err_cnt, 1);
        pulse_clear();
        chk("par_clr", err_cnt, 0);

        // Overflow with DEPTH=4, then drain in order
        send_frame(8'h1C, 1'b0, 11, 1'b0);
        send_frame(8'h32, 1'b0, 11, 1'b0);
        send_frame(8'h21, 1'b0, 11, 1'b0);
        send_frame(8'h23, 1'b0, 11, 1'b0);
        send_frame(8'h2B, 1'b0, 11, 1'b0);
        chk("ovf_count", fifo_count, 4);
        chk("ovf_flag", overflow, 1);
        chk("ovf_head", out_code, 8'h1C);
        @(negedge clk);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain%0d", i), out_code, exp_q[i]);
            @(negedge clk);
        end
        out_ready = 1'b0;
        chk("drain_empty", out_valid, 0);
        chk("drain_code0", out_code, 0);
        pulse_clear();
        chk("ovf_clr", overflow, 0);

        // Partial frame abandoned by the watchdog
        send_frame(8'h55, 1'b0, 5, 1'b0);
        repeat (TIMEOUT + 5) @(negedge clk);
        chk("to_err", err_cnt, 1);
        send_frame(8'h24, 1'b0, 11, 1'b0);
        chk("to_count", fifo_count, 1);
        chk("to_code", out_code, 8'h24);
        chk("to_err2", err_cnt, 1);
        pop_one();
        pulse_clear();

        // Reset mid-frame with entries queued and an error counted
        send_frame(8'h1C, 1'b0, 11, 1'b0);
        send_frame(8'h32, 1'b0, 11, 1'b0);
        send_frame(8'h33, 1'b1, 11, 1'b0);
        chk("pre_rst_count", fifo_count, 2);
        chk("pre_rst_err", err_cnt, 1);
        send_frame(8'h33, 1'b0, 6, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_count", fifo_count, 0);
        chk("arst_code", out_code, 0);
        chk("arst_err", err_cnt, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        send_frame(8'h1C, 1'b0, 11, 1'b0);
        chk("post_count", fifo_count, 1);
        chk("post_code", out_code, 8'h1C);
        chk("post_err", err_cnt, 0);
        pop_one();
        chk("post_empty", out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
